// File: rtl/bsg_link_sdr_reset_sequencer_pkg.sv
// Shared types for the SDR link reset sequencer: state encoding, output bundle,
// default timing, and the per-state output decode.
package bsg_link_sdr_reset_sequencer_pkg;

  localparam int link_reset_step_cycles_gp  = 16;
  localparam int link_reset_token_cycles_gp = 8;

  typedef enum logic [2:0] {
    e_seq_hold      = 3'd0,
    e_seq_token     = 3'd1,
    e_seq_token_gap = 3'd2,
    e_seq_up_rel    = 3'd3,
    e_seq_down_rel  = 3'd4,
    e_seq_ds_rel    = 3'd5,
    e_seq_done      = 3'd6
  } bsg_link_reset_seq_state_e;

  typedef struct packed {
    logic token;
    logic uplink;
    logic downlink;
    logic downstream;
    logic core_reset;
    logic done;
  } bsg_link_reset_outs_s;

  localparam bsg_link_reset_outs_s hold_outs_gp = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  function automatic bsg_link_reset_outs_s seq_outs(input bsg_link_reset_seq_state_e s);
    bsg_link_reset_outs_s o;
    o = hold_outs_gp;
    case (s)
      e_seq_token:    o.token = 1'b1;
      e_seq_up_rel:   o.uplink = 1'b0;
      e_seq_down_rel: begin
        o.uplink   = 1'b0;
        o.downlink = 1'b0;
      end
      e_seq_ds_rel: begin
        o.uplink     = 1'b0;
        o.downlink   = 1'b0;
        o.downstream = 1'b0;
      end
      e_seq_done:     o = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      default:        o = hold_outs_gp;
    endcase
    return o;
  endfunction

  function automatic bsg_link_reset_seq_state_e seq_next(input bsg_link_reset_seq_state_e s);
    bsg_link_reset_seq_state_e n;
    case (s)
      e_seq_hold:      n = e_seq_token;
      e_seq_token:     n = e_seq_token_gap;
      e_seq_token_gap: n = e_seq_up_rel;
      e_seq_up_rel:    n = e_seq_down_rel;
      e_seq_down_rel:  n = e_seq_ds_rel;
      default:         n = e_seq_done;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/bsg_link_sdr_reset_sequencer_if.sv
// Restart request in, ordered link/core resets and status out.
interface bsg_link_sdr_reset_sequencer_if;
  logic       restart_i;
  logic       async_token_reset_o;
  logic       async_uplink_reset_o;
  logic       async_downlink_reset_o;
  logic       async_downstream_reset_o;
  logic       core_reset_o;
  logic       done_o;
  logic [2:0] state_o;

  modport master (
    input  restart_i,
    output async_token_reset_o, async_uplink_reset_o, async_downlink_reset_o,
           async_downstream_reset_o, core_reset_o, done_o, state_o
  );

  modport slave (
    output restart_i,
    input  async_token_reset_o, async_uplink_reset_o, async_downlink_reset_o,
           async_downstream_reset_o, core_reset_o, done_o, state_o
  );
endinterface

// File: rtl/bsg_link_sdr_reset_sequencer_phase_counter.sv
// Loadable down-counter with zero flag timing each sequencer phase.
module bsg_link_reset_seq_phase_counter #(
  parameter int width_p       = 5,
  parameter int step_cycles_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic [width_p-1:0] load_val_i,
  input  logic               dec_i,
  output logic               zero_o
);

  localparam logic [width_p-1:0] reset_val_lp = width_p'(step_cycles_p - 1);

  logic [width_p-1:0] r_cnt;

  // Load wins over decrement so a phase change always starts from a full count.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)     r_cnt <= reset_val_lp;
    else if (load_i) r_cnt <= load_val_i;
    else if (dec_i)  r_cnt <= r_cnt - width_p'(1);
  end

  assign zero_o = (r_cnt == '0);

endmodule

// File: rtl/bsg_link_sdr_reset_sequencer.sv
// Ordered bring-up reset sequencer for a bsg_link_sdr channel pair and its core.
// Outputs are registered from the next-state decode, so they are glitch-free.
module bsg_link_sdr_reset_sequencer
  import bsg_link_sdr_reset_sequencer_pkg::*;
#(
  parameter int step_cycles_p  = link_reset_step_cycles_gp,
  parameter int token_cycles_p = link_reset_token_cycles_gp
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  bsg_link_sdr_reset_sequencer_if.master  link_if
);

  localparam int max_cycles_lp = (step_cycles_p > token_cycles_p) ? step_cycles_p : token_cycles_p;
  localparam int cnt_width_lp  = (max_cycles_lp < 1) ? 1 : $clog2(max_cycles_lp + 1);
  localparam logic [cnt_width_lp-1:0] step_load_lp  = cnt_width_lp'(step_cycles_p - 1);
  localparam logic [cnt_width_lp-1:0] token_load_lp = cnt_width_lp'(token_cycles_p - 1);

  bsg_link_reset_seq_state_e r_state, w_state_n;
  bsg_link_reset_outs_s      r_outs, w_outs_n;
  logic                      w_cnt_zero;
  logic                      w_load;
  logic                      w_dec;
  logic [cnt_width_lp-1:0]   w_load_val;

  bsg_link_reset_seq_phase_counter #(
    .width_p      (cnt_width_lp),
    .step_cycles_p(step_cycles_p)
  ) phase_cnt (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .load_i    (w_load),
    .load_val_i(w_load_val),
    .dec_i     (w_dec),
    .zero_o    (w_cnt_zero)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= e_seq_hold;
      r_outs  <= hold_outs_gp;
    end else begin
      r_state <= w_state_n;
      r_outs  <= w_outs_n;
    end
  end

  // Restart outranks phase advance; DONE holds both state and count.
  always_comb begin
    w_state_n  = r_state;
    w_load     = 1'b0;
    w_dec      = 1'b0;
    w_load_val = step_load_lp;
    if (link_if.restart_i) begin
      w_state_n = e_seq_hold;
      w_load    = 1'b1;
    end else if (r_state != e_seq_done) begin
      if (w_cnt_zero) begin
        w_state_n = seq_next(r_state);
        w_load    = 1'b1;
        if (w_state_n == e_seq_token) w_load_val = token_load_lp;
      end else begin
        w_dec = 1'b1;
      end
    end
    w_outs_n = seq_outs(w_state_n);
  end

  assign link_if.async_token_reset_o      = r_outs.token;
  assign link_if.async_uplink_reset_o     = r_outs.uplink;
  assign link_if.async_downlink_reset_o   = r_outs.downlink;
  assign link_if.async_downstream_reset_o = r_outs.downstream;
  assign link_if.core_reset_o             = r_outs.core_reset;
  assign link_if.done_o                   = r_outs.done;
  assign link_if.state_o                  = r_state;

endmodule

// File: tb/tb_bsg_link_sdr_reset_sequencer.sv
// Directed bench for the reset sequencer: S=4/T=2 main instance plus an S=1/T=1 instance.
module tb_bsg_link_sdr_reset_sequencer;

  logic clk;
  logic rst;
  logic restart;
  int   checks;
  int   failures;

  bsg_link_sdr_reset_sequencer_if ifa ();
  bsg_link_sdr_reset_sequencer_if ifb ();

  assign ifa.restart_i = restart;
  assign ifb.restart_i = restart;

  bsg_link_sdr_reset_sequencer #(.step_cycles_p(4), .token_cycles_p(2)) dut_a (
    .clk_i(clk), .reset_i(rst), .link_if(ifa)
  );
  bsg_link_sdr_reset_sequencer #(.step_cycles_p(1), .token_cycles_p(1)) dut_b (
    .clk_i(clk), .reset_i(rst), .link_if(ifb)
  );

  wire [5:0] obs_a = {ifa.async_token_reset_o, ifa.async_uplink_reset_o, ifa.async_downlink_reset_o,
                      ifa.async_downstream_reset_o, ifa.core_reset_o, ifa.done_o};
  wire [5:0] obs_b = {ifb.async_token_reset_o, ifb.async_uplink_reset_o, ifb.async_downlink_reset_o,
                      ifb.async_downstream_reset_o, ifb.core_reset_o, ifb.done_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected state at edge k after release, from the published edge timing.
  function automatic int exp_state(input int k, input int s, input int t);
    if (k < s)         return 0;
    if (k < s + t)     return 1;
    if (k < 2*s + t)   return 2;
    if (k < 3*s + t)   return 3;
    if (k < 4*s + t)   return 4;
    if (k < 5*s + t)   return 5;
    return 6;
  endfunction

  // {token, uplink, downlink, downstream, core_reset, done} per state.
  function automatic logic [5:0] exp_outs(input int st);
    case (st)
      1:       return 6'b111110;
      2:       return 6'b011110;
      3:       return 6'b001110;
      4:       return 6'b000110;
      5:       return 6'b000010;
      6:       return 6'b000001;
      default: return 6'b011110;
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    restart = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    restart = 1'b0;
    #1;
    checks++;
    if (obs_a !== 6'b011110 || ifa.state_o !== 3'd0) begin
      failures++;
      $display("FAIL reset_a outs=%b state=%0d expected outs=011110 state=0", obs_a, ifa.state_o);
    end
    checks++;
    if (obs_b !== 6'b011110 || ifb.state_o !== 3'd0) begin
      failures++;
      $display("FAIL reset_b outs=%b state=%0d expected outs=011110 state=0", obs_b, ifb.state_o);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs_a !== 6'b011110 || ifa.state_o !== 3'd0) begin
      failures++;
      $display("FAIL reset_held outs=%b state=%0d expected outs=011110 state=0", obs_a, ifa.state_o);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_walk();
    int st;
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk);
      #1;
      st = exp_state(k, 4, 2);
      checks++;
      if (obs_a !== exp_outs(st) || ifa.state_o !== 3'(st)) begin
        failures++;
        $display("FAIL walk_a edge=%0d outs=%b state=%0d expected outs=%b state=%0d",
                 k, obs_a, ifa.state_o, exp_outs(st), st);
      end
      if (k <= 8) begin
        st = exp_state(k, 1, 1);
        checks++;
        if (obs_b !== exp_outs(st) || ifb.state_o !== 3'(st)) begin
          failures++;
          $display("FAIL walk_min edge=%0d outs=%b state=%0d expected outs=%b state=%0d",
                   k, obs_b, ifb.state_o, exp_outs(st), st);
        end
      end
    end
  endtask

  task automatic test_restart_pulse();
    int st;
    do_reset();
    for (int k = 1; k <= 38; k++) begin
      @(posedge clk);
      #1;
      st = (k < 15) ? exp_state(k, 4, 2) : exp_state(k - 15, 4, 2);
      checks++;
      if (obs_a !== exp_outs(st) || ifa.state_o !== 3'(st)) begin
        failures++;
        $display("FAIL restart_pulse edge=%0d outs=%b state=%0d expected outs=%b state=%0d",
                 k, obs_a, ifa.state_o, exp_outs(st), st);
      end
      if (k == 14) restart = 1'b1;
      if (k == 15) restart = 1'b0;
    end
  endtask

  task automatic test_restart_hold();
    int st;
    do_reset();
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk);
      #1;
      if (k < 30)       st = exp_state(k, 4, 2);
      else if (k <= 40) st = 0;
      else              st = exp_state(k - 40, 4, 2);
      checks++;
      if (obs_a !== exp_outs(st) || ifa.state_o !== 3'(st)) begin
        failures++;
        $display("FAIL restart_hold edge=%0d outs=%b state=%0d expected outs=%b state=%0d",
                 k, obs_a, ifa.state_o, exp_outs(st), st);
      end
      if (k == 29) restart = 1'b1;
      if (k == 40) restart = 1'b0;
    end
  endtask

  task automatic test_async_reset();
    int st;
    do_reset();
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (ifa.async_token_reset_o !== 1'b1 || ifa.state_o !== 3'd1) begin
      failures++;
      $display("FAIL pre_async token=%b state=%0d expected token=1 state=1",
               ifa.async_token_reset_o, ifa.state_o);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (obs_a !== 6'b011110 || ifa.state_o !== 3'd0) begin
      failures++;
      $display("FAIL async_reset outs=%b state=%0d expected outs=011110 state=0", obs_a, ifa.state_o);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 23; k++) begin
      @(posedge clk);
      #1;
      st = exp_state(k, 4, 2);
      checks++;
      if (obs_a !== exp_outs(st) || ifa.state_o !== 3'(st)) begin
        failures++;
        $display("FAIL after_async edge=%0d outs=%b state=%0d expected outs=%b state=%0d",
                 k, obs_a, ifa.state_o, exp_outs(st), st);
      end
    end
  endtask

  // Ordering invariants sampled mid-cycle throughout the run.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (ifa.done_o === 1'b1 && obs_a[5:1] !== 5'b00000) begin
        failures++;
        $display("FAIL inv_done outs=%b expected resets all 0 when done", obs_a);
      end
      checks++;
      if (ifa.async_uplink_reset_o === 1'b1 &&
          (ifa.async_downlink_reset_o !== 1'b1 || ifa.async_downstream_reset_o !== 1'b1)) begin
        failures++;
        $display("FAIL inv_order outs=%b expected downlink/downstream high while uplink high", obs_a);
      end
      checks++;
      if (ifa.async_token_reset_o === 1'b1 && ifa.state_o !== 3'd1) begin
        failures++;
        $display("FAIL inv_token state=%0d expected 1 while token high", ifa.state_o);
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    restart  = 1'b0;
    test_reset();
    test_walk();
    test_restart_pulse();
    test_restart_hold();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
